// File: rtl/shift_seq.sv
// Multi-cycle 16-bit shift sequencer: one conditional power-of-two stage per clock
// (8, 4, 2, 1) through a shared stage datapath, with valid/ready on both sides.
module shift_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic [AMT_W-1:0] Amt,
    input  logic [1:0]       Op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int IW = (AMT_W > 1) ? $clog2(AMT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_val;
    logic [AMT_W-1:0] amt_r;
    logic [1:0]       op_r;
    logic [IW-1:0]    idx;
    logic [AMT_W:0]   k;
    logic [AMT_W:0]   kc;
    logic             accept;

    // Shared stage: shift the working value by 2**idx, kept only if that amount bit is set.
    always_comb begin
        k  = (AMT_W+1)'(1) << idx;
        kc = (AMT_W+1)'(WIDTH) - k;
        shifted = work;
        case (op_r)
            2'b00:   shifted = (work << k) | (work >> kc);
            2'b01:   shifted = work << k;
            2'b10:   shifted = (work >> k) | (work << kc);
            default: shifted = work >> k;
        endcase
        stage_val = amt_r[idx] ? shifted : work;
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                busy = 1'b1;
                if (idx == '0) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = in_ready & in_valid;
        if (accept) state_next = BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= IW'(AMT_W - 1);
            work  <= '0;
            amt_r <= '0;
            op_r  <= '0;
            Out   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                work  <= In;
                amt_r <= Amt;
                op_r  <= Op;
                idx   <= IW'(AMT_W - 1);
            end else if (state == BUSY) begin
                work <= stage_val;
                if (idx == '0) begin
                    Out <= stage_val;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: directed spec cases, back-pressure, mid-op reset
// and random traffic with random consumer stalls.
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] In;
    logic [3:0]  Amt;
    logic [1:0]  Op;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          nChecks = 0;
    int          nErrors = 0;
    int          nAccepted = 0;
    int          nResults = 0;
    bit          rndMode = 1'b0;
    logic [15:0] expq[$];

    shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .In(In), .Amt(Amt), .Op(Op),
        .in_valid(in_valid), .in_ready(in_ready),
        .Out(Out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: repeated single-bit steps, independent of the stage decomposition.
    function automatic logic [15:0] model(input logic [15:0] v, input logic [3:0] a,
                                          input logic [1:0] op);
        logic [15:0] r;
        r = v;
        for (int j = 0; j < int'(a); j++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("spurious_out", 32'(Out), 32'hDEAD_0000);
                end else begin
                    checkOutput("sb_out", 32'(Out), 32'(expq.pop_front()));
                    nResults++;
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(In, Amt, Op));
                nAccepted++;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] a, input logic [1:0] op);
        bit accepted;
        accepted = 1'b0;
        In = v;
        Amt = a;
        Op = op;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (rndMode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        In = $urandom;
        Amt = $urandom;
        Op = $urandom;
    endtask

    task automatic waitResult(input string tag, input logic [15:0] exp);
        int lat;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_out"}, 32'(Out), 32'(exp));
        checkOutput({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        In = '0;
        Amt = '0;
        Op = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out", 32'(Out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(16'h8001, 4'd1, 2'b00);  waitResult("rol", 16'h0003);
        applyStimulus(16'h00FF, 4'd4, 2'b01);  waitResult("sll", 16'h0FF0);
        applyStimulus(16'h0001, 4'd1, 2'b10);  waitResult("ror1", 16'h8000);
        applyStimulus(16'h1234, 4'd8, 2'b10);  waitResult("ror8", 16'h3412);
        applyStimulus(16'h8000, 4'd15, 2'b11); waitResult("srl15", 16'h0001);
        applyStimulus(16'hFFFF, 4'd0, 2'b11);  waitResult("srl0", 16'hFFFF);

        // Back-pressure: result must sit unchanged in DONE.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(16'h8001, 4'd1, 2'b00);
        waitResult("bp_first", 16'h0003);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out", 32'(Out), 32'h0003);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        In = 16'h0F00;
        Amt = 4'd8;
        Op = 2'b00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult("bp_second", 16'h000F);

        // Reset during the second BUSY cycle.
        @(posedge clk);
        #1;
        applyStimulus(16'h1234, 4'd8, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out", 32'(Out), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            checkOutput("mid_rst_no_stale", 32'(seen), 32'd0);
        end

        rndMode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            applyStimulus(16'($urandom), 4'($urandom), 2'($urandom));
        end
        rndMode = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
        checkOutput("result_count", 32'(nResults), 32'd1008);
        checkOutput("accept_count", 32'(nAccepted), 32'd1009);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer for the 16-bit shift unit: accepts one operand, a 4-bit shift amount and a 2-bit opcode per transaction.
- Applies the shift as a chain of conditional power-of-two stages (8, 4, 2, 1), one stage per clock, reusing a single stage datapath.
- Sits between the ALU issue logic and the writeback mux, with a valid/ready handshake on both sides.
- Opcode encoding is the same as the single-cycle shifter: 00 rotate left, 01 shift left, 10 rotate right, 11 shift right logical.

Parameters:
WIDTH, 16, operand/result width in bits
AMT_W, 4, shift-amount width; number of stage cycles per operation; WIDTH = 2**AMT_W

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
In  input  WIDTH  operand to shift
Amt  input  AMT_W  shift amount, 0..WIDTH-1
Op  input  2  opcode (00 ROL, 01 SLL, 10 ROR, 11 SRL)
in_valid  input  1  requester has a valid In/Amt/Op
in_ready  output  1  sequencer can accept a request this cycle
Out  output  WIDTH  shifted result, stable while out_valid is high
out_valid  output  1  Out holds a completed result
out_ready  input  1  consumer accepts Out this cycle
busy  output  1  high while in the BUSY state

Behaviour:
- Reset (rst high at a clock edge): state = IDLE, stage index = AMT_W-1, Out = 0, out_valid = 0, busy = 0, all internal operand/amount/op registers = 0.
- Reset has priority over every other event. A reset during BUSY or DONE discards the operation and produces no out_valid.
- States:
  - IDLE: in_ready = 1. If in_valid, capture In, Amt and Op, set idx = AMT_W-1, and go to BUSY.
  - BUSY: busy = 1, in_ready = 0. Each cycle, if Amt[idx] = 1, apply the Op shift by 2**idx to the working register; otherwise hold it.
    - If idx = 0, go to DONE. Otherwise decrement idx.
  - DONE: out_valid = 1, Out = working register.
    - If out_ready, leave DONE. If in_valid is also high the same cycle, capture the new request and go to BUSY; otherwise go to IDLE.
    - If out_ready is low, stay in DONE with Out held unchanged.
- in_ready = (state == IDLE) OR (state == DONE AND out_ready). This is combinational from state and out_ready, with no path from in_valid.
- Latency: the request is accepted at edge N and out_valid is high from edge N+AMT_W onward (4 cycles for the defaults). Latency is fixed and independent of Amt, including Amt = 0.
- Throughput: one result every AMT_W+1 cycles when the consumer keeps out_ready high; back-to-back operation is possible through the DONE-to-BUSY path.
- Stage arithmetic, for a shift by k = 2**idx on value v:
  - ROL: {v[W-1-k:0], v[W-1:W-k]}
  - SLL: {v[W-1-k:0], k zeros}
  - ROR: {v[k-1:0], v[W-1:k]}
  - SRL: {k zeros, v[W-1:k]}
  - No sign extension and no carry/flag outputs.
- Out is registered. In IDLE, Out retains the last result (0 after reset); it is meaningful only while out_valid is high.
- In, Amt and Op are sampled only on an accepting edge. Changes while the sequencer is busy have no effect.
- in_valid high while in BUSY: the request is not accepted and the requester must hold it.
- out_valid deasserts on the edge after out_ready is sampled high in DONE.

Test Plan:
- ROL: In=0x8001, Amt=1, Op=00 accepted at edge 0 -> out_valid at edge 4, Out=0x0003, busy high for 4 cycles.
- SLL/ROR: SLL with In=0x00FF, Amt=4 -> 0x0FF0. ROR with In=0x0001, Amt=1 -> 0x8000. ROR with In=0x1234, Amt=8 -> 0x3412.
- SRL boundary: In=0x8000, Amt=15, Op=11 -> 0x0001. In=0xFFFF, Amt=0, Op=11 -> 0xFFFF, still after a 4-cycle latency.
- Back-pressure: hold out_ready=0 for 5 cycles after DONE -> out_valid and Out stay stable, in_ready=0. Then raise out_ready with in_valid=1 carrying In=0x0F00, Amt=8, Op=00 -> new request accepted that cycle, next result 0x000F exactly 4 edges later.
- Reset mid-operation: assert rst in the 2nd BUSY cycle -> the next cycle shows in_ready=1, busy=0, out_valid=0, Out=0, and no stale result ever appears.
- Random: 1000 transactions with random In/Amt/Op and random out_ready -> every result matches the reference model, and no request is dropped or duplicated.
